// File: rtl/spi_flash_cmd_engine.sv
// spi_flash_cmd_engine
// Issues one of three commands (RDID, RDSR, READ) to an M25P16 serial PROM over SPI mode 0 and
// stores the bytes it receives in a small buffer that the display logic reads by index.
//
// Parameters:
//   CLK_DIV   - SPICLK half-period in CCLK cycles (>= 1)
//   MAX_BYTES - receive buffer depth in bytes (>= 3)
//   LEN_W     - width of len
//   IDX_W     - width of rd_idx
// Ports:
//   CCLK, reset_btn           - system clock, asynchronous active-high reset
//   start, cmd_sel, addr, len - command request (sampled only while idle)
//   busy, done, err           - status; done is a one-cycle pulse, err is held until next start
//   rd_idx, rd_data           - combinational buffer read port (8'hFF beyond MAX_BYTES)
//   SPICLK, SPIMOSI, SPIMISO, cs_prom_n - PROM pins
`timescale 1ns / 1ps

module spi_flash_cmd_engine #(
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned MAX_BYTES = 4,
  parameter int unsigned LEN_W     = $clog2(MAX_BYTES + 1),
  parameter int unsigned IDX_W     = 3
) (
  input  logic             CCLK,
  input  logic             reset_btn,
  input  logic             start,
  input  logic [1:0]       cmd_sel,
  input  logic [23:0]      addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             err,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [7:0]       rd_data,
  output logic             SPICLK,
  output logic             SPIMOSI,
  input  logic             SPIMISO,
  output logic             cs_prom_n
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BufW = $clog2(MAX_BYTES);
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    StIdle,
    StCsSetup,
    StShiftOp,
    StShiftAddr,
    StShiftData,
    StCsHold,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [DivW-1:0]  div_q, div_d;
  logic             phase_q, phase_d;      // 0: SPICLK low half of a bit, 1: high half
  logic [4:0]       bit_q, bit_d;
  logic [LEN_W-1:0] byte_q, byte_d;
  logic [LEN_W-1:0] nbytes_q, nbytes_d;
  logic             is_read_q, is_read_d;
  logic [31:0]      tx_q, tx_d;            // {opcode, addr}; bit 31 drives MOSI
  logic [7:0]       rx_q, rx_d;
  logic             err_q, err_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;
  logic             cs_n_q, cs_n_d;

  logic             half_end;
  logic             reject;
  logic [7:0]       opcode;
  logic [LEN_W-1:0] req_bytes;
  logic             wr_en;
  logic [BufW-1:0]  wr_idx;
  logic [7:0]       buf_q [MAX_BYTES];

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    phase_d   = phase_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    nbytes_d  = nbytes_q;
    is_read_d = is_read_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    err_d     = err_q;
    wr_en     = 1'b0;
    wr_idx    = BufW'(byte_q);
    half_end  = (div_q == DivLast);

    // Request decode, only consumed in StIdle.
    opcode    = 8'h00;
    req_bytes = LEN_W'(3);
    reject    = 1'b0;
    case (cmd_sel)
      2'b00: begin
        opcode    = 8'h9F;
        req_bytes = LEN_W'(3);
      end
      2'b01: begin
        opcode    = 8'h05;
        req_bytes = LEN_W'(1);
      end
      2'b10: begin
        opcode    = 8'h03;
        req_bytes = len;
        reject    = (len == '0) || (32'(len) > MAX_BYTES);
      end
      default: reject = 1'b1;
    endcase

    case (state_q)
      StIdle: begin
        if (start) begin
          is_read_d = (cmd_sel == 2'b10);
          nbytes_d  = req_bytes;
          tx_d      = {opcode, addr};
          err_d     = reject;
          div_d     = '0;
          phase_d   = 1'b0;
          bit_d     = '0;
          byte_d    = '0;
          state_d   = reject ? StDone : StCsSetup;
        end
      end
      StCsSetup: begin
        if (half_end) begin
          div_d   = '0;
          state_d = StShiftOp;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StShiftOp, StShiftAddr, StShiftData: begin
        if (!half_end) begin
          div_d = div_q + 1'b1;
        end else begin
          div_d = '0;
          if (!phase_q) begin
            // Rising SPICLK: sample MISO (slave changed it on the previous falling edge).
            phase_d = 1'b1;
            if (state_q == StShiftData) rx_d = {rx_q[6:0], SPIMISO};
          end else begin
            // Falling SPICLK ends the bit; MOSI advances here.
            phase_d = 1'b0;
            tx_d    = {tx_q[30:0], 1'b0};
            bit_d   = bit_q + 5'd1;
            if (state_q == StShiftOp && bit_q == 5'd7) begin
              bit_d   = '0;
              state_d = is_read_q ? StShiftAddr : StShiftData;
            end
            if (state_q == StShiftAddr && bit_q == 5'd23) begin
              bit_d   = '0;
              state_d = StShiftData;
            end
            if (state_q == StShiftData && bit_q == 5'd7) begin
              bit_d  = '0;
              wr_en  = 1'b1;
              byte_d = byte_q + 1'b1;
              if (byte_q == nbytes_q - LEN_W'(1)) state_d = StCsHold;
            end
          end
        end
      end
      StCsHold: begin
        if (half_end) begin
          div_d   = '0;
          state_d = StDone;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Pin values are derived from next state so the pins come straight from flops.
    sclk_d = (state_d inside {StShiftOp, StShiftAddr, StShiftData}) && phase_d;
    cs_n_d = !(state_d inside {StCsSetup, StShiftOp, StShiftAddr, StShiftData, StCsHold});
    mosi_d = (state_d inside {StCsSetup, StShiftOp, StShiftAddr}) ? tx_d[31] : 1'b0;
  end

  always_ff @(posedge CCLK or posedge reset_btn) begin
    if (reset_btn) begin
      state_q   <= StIdle;
      div_q     <= '0;
      phase_q   <= 1'b0;
      bit_q     <= '0;
      byte_q    <= '0;
      nbytes_q  <= '0;
      is_read_q <= 1'b0;
      tx_q      <= '0;
      rx_q      <= '0;
      err_q     <= 1'b0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      phase_q   <= phase_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      nbytes_q  <= nbytes_d;
      is_read_q <= is_read_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      err_q     <= err_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= cs_n_d;
    end
  end

  always_ff @(posedge CCLK or posedge reset_btn) begin
    if (reset_btn) begin
      for (int i = 0; i < int'(MAX_BYTES); i++) buf_q[i] <= 8'h00;
    end else if (wr_en) begin
      buf_q[wr_idx] <= rx_q;
    end
  end

  assign rd_data   = (32'(rd_idx) < MAX_BYTES) ? buf_q[BufW'(rd_idx)] : 8'hFF;
  assign busy      = state_q inside {StCsSetup, StShiftOp, StShiftAddr, StShiftData, StCsHold};
  assign done      = (state_q == StDone);
  assign err       = err_q;
  assign SPICLK    = sclk_q;
  assign SPIMOSI   = mosi_q;
  assign cs_prom_n = cs_n_q;

endmodule

// File: doc/spi_flash_cmd_engine.md
# spi_flash_cmd_engine

Parametrised SPI command engine for the M25P16 serial PROM, generalising the single fixed RDID read into a selectable command set. Supported commands: RDID, RDSR and READ, with a configurable data length and SPI clock divider. Received bytes land in an internal buffer that the LED/LCD display logic reads by index. The block sits between the debounced button/switch front end and the PROM pins (SPICLK, SPIMOSI, SPIMISO, cs_prom_n).

## Interface
- CLK_DIV, 2, SPICLK half-period in CCLK cycles (≥1)
- MAX_BYTES, 4, data buffer depth in bytes (≥3)
- LEN_W, $clog2(MAX_BYTES+1), width of len
- IDX_W, 3, width of rd_idx
- CCLK  in  1  system clock, 50 MHz; one clock domain
- reset_btn  in  1  asynchronous, active-high reset (debounced level)
- start  in  1  request a command; sampled only in IDLE
- cmd_sel  in  2  command select: 00 RDID (0x9F, 3 bytes), 01 RDSR (0x05, 1 byte), 10 READ (0x03 + 24-bit addr, len bytes), 11 reserved
- addr  in  24  READ start address, captured on start
- len  in  LEN_W  READ byte count, captured on start
- busy  out  1  high from the start-accept cycle until done
- done  out  1  one-cycle completion pulse
- err  out  1  high with done when the request was rejected; held until next start
- rd_idx  in  IDX_W  buffer read index
- rd_data  out  8  buffer[rd_idx]; combinational
- SPICLK  out  1  SPI clock, mode 0, idles low
- SPIMOSI  out  1  serial data to PROM, MSB first
- SPIMISO  in  1  serial data from PROM
- cs_prom_n  out  1  PROM chip select, active low

## Operation
- States: IDLE, CS_SETUP, SHIFT_OP, SHIFT_ADDR, SHIFT_DATA, CS_HOLD, DONE.
- IDLE: on start=1, capture cmd_sel, addr and len, then raise busy.
  - Reject (err=1, go directly to DONE, cs_prom_n stays high) when cmd_sel=11, or when READ has len=0 or len>MAX_BYTES.
  - Otherwise clear the byte count and go to CS_SETUP.
- CS_SETUP: cs_prom_n=0 for CLK_DIV cycles with SPICLK=0; MOSI presents the opcode MSB.
- Each bit takes 2·CLK_DIV cycles:
  - SPICLK low half, then high half.
  - MISO is sampled on the rising edge.
  - MOSI changes only on the falling edge, or at the start of the bit.
- SHIFT_OP shifts out 8 opcode bits, then goes to SHIFT_ADDR (READ only) or SHIFT_DATA.
- SHIFT_ADDR shifts out addr[23:0], MSB first.
- SHIFT_DATA shifts in 8·N bits (N = 3, 1 or len). MOSI is held 0.
  - Byte k completes into buffer[k]; byte 0 is the first received.
- CS_HOLD: SPICLK=0, cs_prom_n=0 for CLK_DIV cycles, then cs_prom_n=1.
- DONE: done=1 for one cycle, busy=0, return to IDLE.
- Buffer entries not written by the current command keep their previous values.
- rd_data returns 8'hFF when rd_idx ≥ MAX_BYTES.
- start while busy is ignored.

## Timing
- Reset values: cs_prom_n=1, SPICLK=0, SPIMOSI=0, busy=0, done=0, err=0, state IDLE, all buffer bytes 8'h00.
- reset_btn mid-transaction takes effect immediately and asynchronously:
  - cs_prom_n goes high and SPICLK low.
  - The partial byte is discarded and the buffer is cleared.
- Latency: if the start is accepted at cycle 0, done is high at cycle (2·B+2)·CLK_DIV+1, where B = 8+24·(READ)+8·N.
  - RDID at CLK_DIV=2: B=32, so done at cycle 133.
- Rejected request: done and err are high at cycle 1.
- busy falls in the same cycle that done rises.
- rd_data settles in the same cycle rd_idx changes.

## Test plan
- RDID against the m25p16 model, CLK_DIV=2 → buffer[0..2] = 0x20, 0x20, 0x15; rd_idx=3 and rd_idx=7 → 0xFF; done at cycle 133.
- RDSR → rd_data[0]=0x00, exactly 16 SPICLK rising edges while cs_prom_n=0, done after one byte.
- READ, addr=0x000000, len=4, model preloaded with 0x01, 0x02, 0x03, 0x04 → buffer = 01 02 03 04; the first 32 MOSI bits are 0x03000000.
- cmd_sel=11, then READ with len=0, then len=MAX_BYTES+1 → each gives err=1 and done at cycle 1; cs_prom_n never goes low.
- start pulsed repeatedly during an RDID → only one transaction (32 SPICLK edges, one done).
- reset_btn asserted after 10 SPICLK edges of RDID → cs_prom_n=1 and SPICLK=0 immediately; buffer reads 0x00. A following RDID completes normally with 0x20, 0x20, 0x15.
